fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 161 ++++++++++++++++
 tb/tb_fetch_queue.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction fetch front end. It walks a PC through instruction memory,
//   buffers the returned words with their addresses in a small in-order
//   queue, and hands them to decode through a valid/ready port. A redirect
//   from the back end flushes everything and restarts fetch at a new PC.
//
// Configuration macro:
//   FETCH_QUEUE_PERF_CNT_EN - when defined, stall_count counts the cycles
//                             where the head is valid but decode is not
//                             ready (saturating). When undefined, the
//                             counter is absent and stall_count reads 0.
//
// Parameters:
//   INIT_ADDRESS  - PC loaded on reset
//   DEPTH         - queue entries (power of two, >= 2)
//
// Ports:
//   clk, reset                 - single clock, synchronous active-high reset
//   imem_req / imem_addr       - fetch request and its address (current PC)
//   imem_ready                 - memory accepts the request this cycle
//   imem_rdata                 - instruction word, one cycle after acceptance
//   redirect_valid/redirect_pc - flush the queue and restart at redirect_pc
//   out_valid / out_ready      - head-of-queue handshake towards decode
//   out_instr / out_pc         - head instruction word and its address
//   out_pc_plus4               - out_pc + 4 (wraps modulo 2^32)
//   stall_count                - head-valid-but-not-consumed cycle counter

module fetch_queue #(
  parameter logic [31:0] INIT_ADDRESS = 32'h0000_0000,
  parameter int          DEPTH        = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic [31:0] stall_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [31:0]   r_pc;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic          r_inflight;
  logic [31:0]   r_inflightPc;
  logic [31:0]   r_instrMem [DEPTH];
  logic [31:0]   r_pcMem    [DEPTH];

  logic [CW:0]   w_occupancy;
  logic          w_req;
  logic          w_accept;
  logic          w_push;
  logic          w_valid;
  logic          w_pop;

  // Queued entries plus the response still on its way. Requests are only
  // issued while this is below DEPTH, so every response has a free slot
  // waiting for it and the memory side never needs back-pressure.
  assign w_occupancy = {1'b0, r_count} + (CW + 1)'(r_inflight);

  // A redirect outranks everything: no new request and no pop in that cycle.
  // Reset also blocks both so nothing leaves or enters while it is held.
  assign w_req    = !reset && !redirect_valid && (w_occupancy < DEPTH_OCC);
  assign w_accept = w_req && imem_ready;

  // Clearing r_inflight on redirect or reset is what kills a pending
  // response; a response landing in the redirect cycle itself is dropped
  // here because the queue is being flushed anyway.
  assign w_push  = r_inflight && !redirect_valid && !reset;
  assign w_valid = (r_count != '0) && !redirect_valid && !reset;
  assign w_pop   = w_valid && out_ready;

  assign imem_req     = w_req;
  assign imem_addr    = r_pc;
  assign out_valid    = w_valid;
  assign out_instr    = r_instrMem[r_rptr];
  assign out_pc       = r_pcMem[r_rptr];
  assign out_pc_plus4 = r_pcMem[r_rptr] + 32'd4;

  // PC, pointers, occupancy and the in-flight tracker. Pointers are AW bits
  // wide, so they wrap from DEPTH-1 to 0 on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= INIT_ADDRESS;
      r_count      <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_inflight   <= 1'b0;
      r_inflightPc <= '0;
    end else if (redirect_valid) begin
      r_pc       <= redirect_pc;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_accept;
      if (w_accept) begin
        r_pc         <= r_pc + 32'd4;
        r_inflightPc <= r_pc;
      end
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage carries no reset: its contents are only ever observed
  // through out_valid, which is driven purely by the reset-cleared count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instrMem[r_wptr] <= imem_rdata;
      r_pcMem[r_wptr]    <= r_inflightPc;
    end
  end

`ifdef FETCH_QUEUE_PERF_CNT_EN
  logic [31:0] r_stallCount;

  // Counts cycles where decode is holding off a valid head; saturates
  // instead of wrapping so a long stall never reads back as a short one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stallCount <= '0;
    end else if (w_valid && !out_ready && (r_stallCount != 32'hFFFF_FFFF)) begin
      r_stallCount <= r_stallCount + 32'd1;
    end
  end

  assign stall_count = r_stallCount;
`else
  assign stall_count = 32'h0000_0000;
`endif

  // The issue rule guarantees a free slot for every response, so a push
  // into a full queue with no simultaneous pop means that rule is broken.
  assert property (@(posedge clk) disable iff (reset)
    !(w_push && !w_pop && (r_count == DEPTH_CNT)));

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//   Directed bench for fetch_queue (INIT_ADDRESS = 32'h100, DEPTH = 4).
//   A behavioural instruction memory answers each accepted request one
//   cycle later with (address ^ INSTR_KEY). Expected head addresses are
//   queued by the stimulus; a monitor pops and compares them whenever the
//   DUT hands an instruction to decode.

module tb_fetch_queue;

  localparam logic [31:0] INSTR_KEY = 32'h5A5A_A5A5;
`ifdef FETCH_QUEUE_PERF_CNT_EN
  localparam logic [31:0] EXP_STALL = 32'd10;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [31:0] stall_count;

  int checksMade   = 0;
  int checksFailed = 0;

  logic [31:0] expQ[$];

  logic        pendAcc  = 1'b0;
  logic [31:0] pendAddr = 32'h0;

  fetch_queue #(
    .INIT_ADDRESS (32'h0000_0100),
    .DEPTH        (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .stall_count    (stall_count)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: note acceptance mid-cycle, present the word during the
  // following cycle, and drive a junk pattern whenever nothing is due.
  always @(negedge clk) begin
    pendAcc  = imem_req & imem_ready;
    pendAddr = imem_addr;
  end

  always @(posedge clk) begin
    #1;
    imem_rdata = pendAcc ? (pendAddr ^ INSTR_KEY) : 32'hDEAD_DEAD;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checksMade++;
    if (actual !== expected) begin
      checksFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Waits for the next rising edge, drives this cycle's inputs, then lets
  // combinational outputs settle before returning.
  task automatic applyStimulus(input logic rst, input logic rdy, input logic ordy,
                               input logic redir, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    reset          = rst;
    imem_ready     = rdy;
    out_ready      = ordy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic expectPc(input logic [31:0] pc);
    expQ.push_back(pc);
  endtask

  // Monitor: every instruction consumed by decode must be the next one
  // the scoreboard expects, with matching word and pc+4.
  always @(negedge clk) begin
    logic [31:0] exp;
    if (!reset && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checksMade++;
        checksFailed++;
        $display("[TB] FAIL unexpected_output: got pc %h, expected no output", out_pc);
      end else begin
        exp = expQ.pop_front();
        checkOutput("sb_pc", out_pc, exp);
        checkOutput("sb_instr", out_instr, exp ^ INSTR_KEY);
        checkOutput("sb_pc_plus4", out_pc_plus4, exp + 32'd4);
      end
    end
  end

  initial begin
    reset          = 1'b1;
    imem_ready     = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_rdata     = 32'hDEAD_DEAD;

    // Reset behaviour
    applyStimulus(1, 1, 1, 0, 32'h0);
    applyStimulus(1, 1, 1, 0, 32'h0);
    checkOutput("reset_req", 32'(imem_req), 32'h0);
    checkOutput("reset_valid", 32'(out_valid), 32'h0);
    checkOutput("reset_stall", stall_count, 32'h0);

    // Free-running fetch from INIT_ADDRESS, two-cycle latency
    expectPc(32'h100); expectPc(32'h104); expectPc(32'h108); expectPc(32'h10C);
    applyStimulus(0, 1, 1, 0, 32'h0);
    checkOutput("first_req", 32'(imem_req), 32'h1);
    checkOutput("first_addr", imem_addr, 32'h100);
    applyStimulus(0, 1, 1, 0, 32'h0);
    checkOutput("lat_not_yet", 32'(out_valid), 32'h0);
    checkOutput("second_addr", imem_addr, 32'h104);
    applyStimulus(0, 1, 1, 0, 32'h0);
    checkOutput("lat_valid", 32'(out_valid), 32'h1);
    checkOutput("lat_pc", out_pc, 32'h100);
    applyStimulus(0, 1, 1, 0, 32'h0);
    checkOutput("stream_addr", imem_addr, 32'h10C);
    applyStimulus(0, 1, 1, 0, 32'h0);
    applyStimulus(0, 1, 1, 0, 32'h0);
    applyStimulus(1, 1, 1, 0, 32'h0);
    checkOutput("midreset_req", 32'(imem_req), 32'h0);
    checkOutput("midreset_valid", 32'(out_valid), 32'h0);

    // Fill to DEPTH with decode stalled, then drain in order
    expectPc(32'h100); expectPc(32'h104); expectPc(32'h108);
    expectPc(32'h10C); expectPc(32'h110); expectPc(32'h114);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 1, 0, 0, 32'h0);
      if (i == 3) checkOutput("fill_addr", imem_addr, 32'h10C);
      if (i == 4) checkOutput("full_req_off", 32'(imem_req), 32'h0);
      if (i == 5) begin
        checkOutput("full_req_held", 32'(imem_req), 32'h0);
        checkOutput("full_head_valid", 32'(out_valid), 32'h1);
        checkOutput("full_head_pc", out_pc, 32'h100);
      end
    end
    applyStimulus(0, 1, 1, 0, 32'h0);
    checkOutput("stall_count", stall_count, EXP_STALL);
    checkOutput("drain_req_off", 32'(imem_req), 32'h0);
    applyStimulus(0, 1, 1, 0, 32'h0);
    checkOutput("resume_req", 32'(imem_req), 32'h1);
    checkOutput("resume_addr", imem_addr, 32'h110);
    checkOutput("stall_hold", stall_count, EXP_STALL);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 0, 32'h0);
    applyStimulus(1, 1, 1, 0, 32'h0);

    // Redirect with three queued entries and one response in flight
    applyStimulus(0, 1, 0, 0, 32'h0);
    checkOutput("stall_cleared", stall_count, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 32'h0);
    applyStimulus(0, 1, 1, 1, 32'h2000);
    checkOutput("redir_req_off", 32'(imem_req), 32'h0);
    checkOutput("redir_valid_off", 32'(out_valid), 32'h0);
    expectPc(32'h2000); expectPc(32'h2004);
    applyStimulus(0, 1, 1, 0, 32'h0);
    checkOutput("post_redir_valid", 32'(out_valid), 32'h0);
    checkOutput("post_redir_addr", imem_addr, 32'h2000);
    checkOutput("post_redir_req", 32'(imem_req), 32'h1);
    applyStimulus(0, 1, 1, 0, 32'h0);
    applyStimulus(0, 1, 1, 0, 32'h0);
    checkOutput("redir_head_pc", out_pc, 32'h2000);
    applyStimulus(0, 1, 1, 0, 32'h0);

    // Back-to-back redirects; the second one (near the top of memory) wins
    applyStimulus(0, 1, 1, 1, 32'h5000);
    applyStimulus(0, 1, 1, 1, 32'hFFFF_FFF8);
    checkOutput("b2b_req_off", 32'(imem_req), 32'h0);
    expectPc(32'hFFFF_FFF8); expectPc(32'hFFFF_FFFC); expectPc(32'h0);
    expectPc(32'h4); expectPc(32'h8); expectPc(32'hC); expectPc(32'h10);
    applyStimulus(0, 1, 1, 0, 32'h0);
    checkOutput("b2b_addr", imem_addr, 32'hFFFF_FFF8);
    checkOutput("b2b_valid_off", 32'(out_valid), 32'h0);
    applyStimulus(0, 1, 1, 0, 32'h0);
    checkOutput("top_addr", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(0, 1, 1, 0, 32'h0);
    checkOutput("wrap_addr", imem_addr, 32'h0);
    applyStimulus(0, 1, 1, 0, 32'h0);
    checkOutput("wrap_head_pc", out_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_pc_plus4", out_pc_plus4, 32'h0);

    // Memory ready toggling, then drain with no new acceptances
    for (int i = 0; i < 6; i++) applyStimulus(0, 1'(i % 2), 1, 0, 32'h0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 0, 32'h0);
    checkOutput("sb_drained", 32'(expQ.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checksMade, checksFailed);
    $finish;
  end

endmodule
